// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit seven-segment display: digit select, active-low anodes,
// inter-digit blanking, frame-synchronous digit shadow, leading-zero blanking and blinking.
//
// state    | meaning
// ST_BLANK | all anodes off, segments forced off, BLANK_CYC cycles before each slot
// ST_SHOW  | digit sel lit (unless suppressed) for REFRESH_DIV cycles
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYC    = 1000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    input  logic        lz_blank,
    output logic [15:0] dig_q,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic        blank,
    output logic        frame_done,
    output logic        load_ack
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    an_q, an_d;
    logic          blank_q, blank_d;
    logic          fd_q, fd_d;
    logic          ack_q, ack_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   pend_q, pend_d;
    logic          pv_q, pv_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          hidden_q, hidden_d;
    logic          boundary;
    logic [3:0]    lz_sup;
    logic [3:0]    supp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BLANK;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            an_q     <= 4'b1111;
            blank_q  <= 1'b1;
            fd_q     <= 1'b0;
            ack_q    <= 1'b0;
            shadow_q <= 16'h0000;
            pend_q   <= 16'h0000;
            pv_q     <= 1'b0;
            bcnt_q   <= '0;
            hidden_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            an_q     <= an_d;
            blank_q  <= blank_d;
            fd_q     <= fd_d;
            ack_q    <= ack_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pv_q     <= pv_d;
            bcnt_q   <= bcnt_d;
            hidden_q <= hidden_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        sel_d    = sel_q;
        boundary = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    sel_d    = sel_q + 2'd1;
                    boundary = (sel_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Leading-zero run propagates downward from the most significant digit.
        lz_sup[3] = lz_blank && (shadow_q[15:12] == 4'h0);
        lz_sup[2] = lz_sup[3] && (shadow_q[11:8] == 4'h0);
        lz_sup[1] = lz_sup[2] && (shadow_q[7:4] == 4'h0);
        lz_sup[0] = 1'b0;
        supp      = (blink_mask & {4{hidden_q}}) | lz_sup;

        an_d    = 4'b1111;
        blank_d = 1'b1;
        if (state_d == ST_SHOW && !supp[sel_d]) begin
            an_d    = ~(4'b0001 << sel_d);
            blank_d = 1'b0;
        end

        shadow_d = shadow_q;
        pend_d   = pend_q;
        pv_d     = pv_q;
        ack_d    = 1'b0;
        if (boundary) begin
            if (load) begin
                shadow_d = digits_in;
                pv_d     = 1'b0;
                ack_d    = 1'b1;
            end else if (pv_q) begin
                shadow_d = pend_q;
                pv_d     = 1'b0;
                ack_d    = 1'b1;
            end
        end else if (load) begin
            pend_d = digits_in;
            pv_d   = 1'b1;
        end

        bcnt_d   = bcnt_q;
        hidden_d = hidden_q;
        if (boundary) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d   = '0;
                hidden_d = ~hidden_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end

        fd_d = boundary;
    end

    assign dig_q      = shadow_q;
    assign sel        = sel_q;
    assign an         = an_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;
    assign load_ack   = ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a small timing (frame = 24 cycles); expected outputs are
// queued per cycle by the stimulus and checked by an independent negedge monitor.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blink_mask;
    logic        lz_blank;
    logic [15:0] dig_q;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic        blank;
    logic        frame_done;
    logic        load_ack;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .load      (load),
        .blink_mask(blink_mask),
        .lz_blank  (lz_blank),
        .dig_q     (dig_q),
        .sel       (sel),
        .an        (an),
        .blank     (blank),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [3:0]  an;
        logic        blank;
        logic        fd;
        logic        ack;
        logic [15:0] dig;
    } exp_t;

    exp_t        cyc_q[$];
    logic [15:0] ack_q[$];
    int          total = 0;
    int          bad   = 0;
    int          t     = 0;
    logic [15:0] m_dig  = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    logic        m_pv   = 1'b0;
    exp_t        mon_e;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    function automatic logic lead_zero(input logic [15:0] d, input int i);
        if (i == 0) return 1'b0;
        for (int j = i; j < 4; j++)
            if (d[4*j +: 4] != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock and queue what the DUT must show during the new cycle.
    task automatic step();
        logic        s_rst, s_load, s_lz, show, supp, hidden, landed;
        logic [15:0] s_din;
        logic [3:0]  s_mask;
        int          pos, slot;
        exp_t        e;
        @(posedge clk);
        s_rst  = rst;
        s_load = load;
        s_din  = digits_in;
        s_mask = blink_mask;
        s_lz   = lz_blank;
        e.ack  = 1'b0;
        e.fd   = 1'b0;
        if (s_rst) begin
            t     = 0;
            m_dig = 16'h0000;
            m_pv  = 1'b0;
        end else begin
            t++;
            landed = (t % 24 == 0);
            if (landed) begin
                if (s_load) begin
                    m_dig = s_din;
                    m_pv  = 1'b0;
                    e.ack = 1'b1;
                end else if (m_pv) begin
                    m_dig = m_pend;
                    m_pv  = 1'b0;
                    e.ack = 1'b1;
                end
            end else if (s_load) begin
                m_pend = s_din;
                m_pv   = 1'b1;
            end
            e.fd = landed;
        end
        pos    = t % 24;
        slot   = pos / 6;
        show   = !s_rst && (pos % 6) >= 2;
        hidden = (((t / 24) / 2) % 2) == 1;
        supp   = (s_mask[slot] && hidden) || (s_lz && lead_zero(m_dig, slot));
        e.sel  = 2'(slot);
        e.dig  = m_dig;
        e.an   = 4'hF;
        e.blank = 1'b1;
        if (show && !supp) begin
            e.an[slot] = 1'b0;
            e.blank    = 1'b0;
        end
        cyc_q.push_back(e);
        if (e.ack) ack_q.push_back(m_dig);
        #1;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (t != target) begin
            step();
            guard++;
            if (guard > 1000) begin
                $display("FAIL run_to target=%0d got_t=%0d", target, t);
                $fatal(1, "cycle budget exceeded");
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_e = cyc_q.pop_front();
            check("sel",        {14'd0, sel},        {14'd0, mon_e.sel});
            check("an",         {12'd0, an},         {12'd0, mon_e.an});
            check("blank",      {15'd0, blank},      {15'd0, mon_e.blank});
            check("frame_done", {15'd0, frame_done}, {15'd0, mon_e.fd});
            check("load_ack",   {15'd0, load_ack},   {15'd0, mon_e.ack});
            check("dig_q",      dig_q,               mon_e.dig);
        end
        if (load_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_event t=%0d got=load_ack want=none", t);
            end else begin
                check("ack_data", dig_q, ack_q.pop_front());
            end
        end
    end

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        digits_in  = 16'h0000;
        blink_mask = 4'b0000;
        lz_blank   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // load mid-frame, lands at the first boundary
        run_to(5);
        load = 1'b1; digits_in = 16'h1234; step(); load = 1'b0;

        // leading-zero blanking with 0045, then with 0000
        run_to(30);
        load = 1'b1; digits_in = 16'h0045; step(); load = 1'b0;
        lz_blank = 1'b1;
        run_to(60);
        load = 1'b1; digits_in = 16'h0000; step(); load = 1'b0;
        run_to(95);
        lz_blank = 1'b0;

        // blink digit 0 across frames 4..9
        blink_mask = 4'b0001;
        run_to(239);
        blink_mask = 4'b0000;

        // pending overwritten by a load on the boundary cycle itself
        run_to(245);
        load = 1'b1; digits_in = 16'h1111; step(); load = 1'b0;
        run_to(263);
        load = 1'b1; digits_in = 16'hABCD; step(); load = 1'b0;

        // reset in SHOW of slot 2 with a pending value
        run_to(290);
        load = 1'b1; digits_in = 16'h5555; step(); load = 1'b0;
        run_to(303);
        rst = 1'b1; step(); rst = 1'b0;
        run_to(30);

        repeat (2) @(negedge clk);
        check("cyc_queue_left", 16'(cyc_q.size()), 16'd0);
        check("ack_queue_left", 16'(ack_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
